// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory block port between the icache and
// dcache controllers. A granted request has its block address (and, for a
// write-back, its data) latched, and the memory request is held until memory
// completes it. The completion is then routed back to the owning controller.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, contested
// icache/dcache arbitration alternates between the two sides. When it is
// undefined, the dcache always has priority over the icache.
module mem_port_arbiter #(
  parameter int BLOCK_ADDR_W = 28,
  parameter int BLOCK_BITS   = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_ren,
  input  logic [BLOCK_ADDR_W-1:0] i_block_addr,
  output logic                    i_read_ready,
  output logic [BLOCK_BITS-1:0]   i_dout,
  input  logic                    d_ren,
  input  logic                    d_wen,
  input  logic [BLOCK_ADDR_W-1:0] d_block_addr,
  input  logic [BLOCK_BITS-1:0]   d_din,
  output logic                    d_read_ready,
  output logic                    d_write_done,
  output logic [BLOCK_BITS-1:0]   d_dout,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [BLOCK_ADDR_W-1:0] mem_block_addr,
  output logic [BLOCK_BITS-1:0]   mem_din,
  input  logic                    mem_read_ready,
  input  logic                    mem_write_done,
  input  logic [BLOCK_BITS-1:0]   mem_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_READ  = 2'd1,
    D_READ  = 2'd2,
    D_WRITE = 2'd3
  } arbState_t;

  arbState_t               state;
  arbState_t               nextGrant;
  arbState_t               dKind;
  logic                    dPending;
  logic                    stickyRefill;
  logic                    memRenQ;
  logic                    memWenQ;
  logic [BLOCK_ADDR_W-1:0] addrQ;
  logic [BLOCK_BITS-1:0]   dinQ;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // lastWinner: 0 = icache won the last contested grant, 1 = dcache did
  logic                    lastWinner;
  logic                    contested;
`endif

  // Arbitration: write-back before refill on the dcache side. A refill that
  // follows a write-back keeps the port (sticky). Otherwise the dcache wins
  // over the icache, or the sides alternate when round-robin is enabled.
  always_comb begin
    nextGrant = IDLE;
    dPending  = d_ren | d_wen;
    dKind     = d_wen ? D_WRITE : D_READ;
    if (stickyRefill && d_ren) begin
      nextGrant = D_READ;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    else if (dPending && i_ren) begin
      nextGrant = lastWinner ? I_READ : dKind;
    end
`endif
    else if (dPending) begin
      nextGrant = dKind;
    end else if (i_ren) begin
      nextGrant = I_READ;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A contest is a simultaneous icache/dcache request that the sticky rule does not settle
  assign contested = dPending && i_ren && !(stickyRefill && d_ren);

  // Remember which side won the most recent contested arbitration
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastWinner <= 1'b0;
    end else if (state == IDLE && contested) begin
      lastWinner <= (nextGrant != I_READ);
    end
  end
`endif

  // Main FSM: grant from IDLE, hold the registered memory request until completion
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      memRenQ      <= 1'b0;
      memWenQ      <= 1'b0;
      addrQ        <= '0;
      dinQ         <= '0;
      stickyRefill <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (nextGrant != IDLE) begin
            state        <= nextGrant;
            stickyRefill <= 1'b0;
            addrQ        <= (nextGrant == I_READ) ? i_block_addr : d_block_addr;
            if (nextGrant == D_WRITE) begin
              dinQ <= d_din;
            end
            memRenQ <= (nextGrant != D_WRITE);
            memWenQ <= (nextGrant == D_WRITE);
          end
        end
        I_READ, D_READ: begin
          if (mem_read_ready) begin
            state   <= IDLE;
            memRenQ <= 1'b0;
          end
        end
        D_WRITE: begin
          if (mem_write_done) begin
            state        <= IDLE;
            memWenQ      <= 1'b0;
            stickyRefill <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          memRenQ <= 1'b0;
          memWenQ <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ren        = memRenQ;
  assign mem_wen        = memWenQ;
  assign mem_block_addr = addrQ;
  assign mem_din        = dinQ;

  // Completions reach only the owner, and only while it still holds its request
  assign i_read_ready = (state == I_READ)  && mem_read_ready && i_ren;
  assign d_read_ready = (state == D_READ)  && mem_read_ready && d_ren;
  assign d_write_done = (state == D_WRITE) && mem_write_done && d_wen;

  assign i_dout = (state == I_READ) ? mem_dout : '0;
  assign d_dout = (state == D_READ) ? mem_dout : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one main-memory block port between the icache and dcache controllers. Both controllers issue miss refills and dcache write-backs here.
- Grants one requester at a time and latches its block address and write data. Holds the memory request until the memory completes it, then routes the completion back to the owner.
- Sits between the two cache controllers and the single external memory interface at cpu level.

Parameters:
- BLOCK_ADDR_W, 28, width of the block address (tag+index) on every port.
- BLOCK_BITS, 256, width of one cache block data bus.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_ren  in  1  icache refill request; level, held until i_read_ready.
- i_block_addr  in  BLOCK_ADDR_W  icache refill block address.
- i_read_ready  out  1  icache refill data valid on i_dout this cycle.
- i_dout  out  BLOCK_BITS  refill data to icache.
- d_ren  in  1  dcache refill request; level, held until d_read_ready.
- d_wen  in  1  dcache write-back request; level, held until d_write_done.
- d_block_addr  in  BLOCK_ADDR_W  dcache block address.
- d_din  in  BLOCK_BITS  write-back data.
- d_read_ready  out  1  dcache refill data valid on d_dout.
- d_write_done  out  1  dcache write-back accepted.
- d_dout  out  BLOCK_BITS  refill data to dcache.
- mem_ren  out  1  memory read request.
- mem_wen  out  1  memory write request.
- mem_block_addr  out  BLOCK_ADDR_W  latched address of the granted request.
- mem_din  out  BLOCK_BITS  latched write data.
- mem_read_ready  in  1  memory read data valid.
- mem_write_done  in  1  memory write complete.
- mem_dout  in  BLOCK_BITS  memory read data.

Behaviour:
- FSM states: IDLE, I_READ, D_READ, D_WRITE. Reset (reset==0, asynchronous) forces IDLE and clears the latches and the sticky flag.
- Reset values: every output 0; mem_block_addr and mem_din cleared to 0.
- IDLE arbitration, evaluated each cycle:
  - d_wen takes precedence over d_ren.
  - The dcache takes precedence over the icache.
  - If the sticky flag is set and d_ren is high, grant D_READ regardless of i_ren, then clear the flag.
- On grant: latch the address into mem_block_addr and, for writes, d_din into mem_din. Enter the granted state on the next edge. This gives one cycle of grant latency from IDLE.
- I_READ / D_READ:
  - mem_ren=1 (registered) until mem_read_ready.
  - In the mem_read_ready cycle, the owner's read_ready = mem_read_ready & (owner ren still high), combinational. The owner's dout = mem_dout.
  - Return to IDLE on the next edge.
- D_WRITE:
  - mem_wen=1 until mem_write_done. d_write_done = mem_write_done & d_wen.
  - Return to IDLE and set the sticky flag, so a write-back followed by its refill is never split by an icache grant.
- A requester that drops its request mid-transaction does not abort the memory access. The arbiter still waits for completion, suppresses the ready/done, and returns to IDLE.
- mem_ren and mem_wen are never high together. Neither is high in IDLE, so there is a minimum one-cycle gap between transactions.
- Non-owners' ready/done outputs stay 0 at all times. i_dout and d_dout may both mirror mem_dout.
- Latched address and data stay stable for the whole transaction even if the request inputs change.
- A memory completion (ready/done) arriving while in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when i_ren and a dcache request are both pending in IDLE and the sticky flag is clear, the grant goes to the requester that did not win the last contested arbitration. A one-bit last_winner register is cleared to the icache side on reset. The sticky rule still overrides round-robin.
- Undefined: fixed dcache-first priority as described above; no last_winner register.

Test Plan:
- i_ren=1, i_block_addr=0x0000040; memory answers 3 cycles after mem_ren:
  - mem_ren rises 1 cycle after i_ren with mem_block_addr=0x0000040.
  - i_read_ready pulses 1 cycle with i_dout=mem_dout; d_read_ready stays 0.
- d_wen=1, addr 0x0000123, d_din=all-0xA5; then d_ren=1 with i_ren=1 held throughout:
  - mem_wen asserts with mem_din=all-0xA5.
  - After d_write_done, D_READ is granted before I_READ.
- i_ren and d_ren asserted in the same cycle, macro undefined -> D_READ granted first, I_READ second.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN defined, repeated twice -> grants alternate D, I, I, D.
- d_ren dropped 1 cycle after grant -> mem_ren held until mem_read_ready; d_read_ready stays 0; FSM back in IDLE.
- reset driven low mid D_WRITE -> mem_wen and all ready/done outputs 0 immediately (asynchronous); FSM in IDLE after reset releases.
